// File: rtl/wb_arbiter_2m1s.sv
// Two-master, one-slave Wishbone arbiter: round-robin with same-cycle grant,
// ownership held for the whole master cycle, watchdog synthetic ack on slave stall.
module wb_arbiter_2m1s #(
   parameter int unsigned           ADDR_WIDTH   = 32,
   parameter int unsigned           DATA_WIDTH   = 32,
   parameter int unsigned           SEL_WIDTH    = 4,
   parameter logic [15:0]           TIMEOUT      = 16'd255,
   parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = DATA_WIDTH'(32'hDEAD_BEEF)
) (
   input  logic                  clk,
   input  logic                  rst,
   // master 0 (instruction-side bridge)
   input  logic                  m0_cyc_i,
   input  logic                  m0_stb_i,
   input  logic                  m0_we_i,
   input  logic [ADDR_WIDTH-1:0] m0_addr_i,
   input  logic [DATA_WIDTH-1:0] m0_data_i,
   input  logic [SEL_WIDTH-1:0]  m0_sel_i,
   output logic [DATA_WIDTH-1:0] m0_data_o,
   output logic                  m0_ack_o,
   // master 1 (data-side bridge)
   input  logic                  m1_cyc_i,
   input  logic                  m1_stb_i,
   input  logic                  m1_we_i,
   input  logic [ADDR_WIDTH-1:0] m1_addr_i,
   input  logic [DATA_WIDTH-1:0] m1_data_i,
   input  logic [SEL_WIDTH-1:0]  m1_sel_i,
   output logic [DATA_WIDTH-1:0] m1_data_o,
   output logic                  m1_ack_o,
   // shared slave
   output logic                  s_cyc_o,
   output logic                  s_stb_o,
   output logic                  s_we_o,
   output logic [ADDR_WIDTH-1:0] s_addr_o,
   output logic [DATA_WIDTH-1:0] s_data_o,
   output logic [SEL_WIDTH-1:0]  s_sel_o,
   input  logic [DATA_WIDTH-1:0] s_data_i,
   input  logic                  s_ack_i,
   // status
   output logic [1:0]            grant_o,
   output logic                  timeout_o
);

   localparam int unsigned CNT_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t               state;
   state_t               state_next;
   logic                 rr_ptr;
   logic                 rr_ptr_next;
   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] cnt_next;
   logic                 owner_valid;
   logic                 owner_idx;
   logic                 in_grant;
   logic                 wd_fire;

   // State, round-robin pointer, watchdog counter and sticky timeout flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= 1'b0;
         cnt       <= '0;
         timeout_o <= 1'b0;
      end else begin
         state     <= state_next;
         rr_ptr    <= rr_ptr_next;
         cnt       <= cnt_next;
         timeout_o <= timeout_o | wd_fire;
      end
   end

   // Owner selection, next state, slave routing, ack/data return, watchdog
   always_comb begin
      state_next  = state;
      rr_ptr_next = rr_ptr;
      owner_valid = 1'b0;
      owner_idx   = 1'b0;
      in_grant    = 1'b0;
      wd_fire     = 1'b0;
      s_cyc_o     = 1'b0;
      s_stb_o     = 1'b0;
      s_we_o      = 1'b0;
      s_addr_o    = '0;
      s_data_o    = '0;
      s_sel_o     = '0;
      grant_o     = 2'b00;
      m0_ack_o    = 1'b0;
      m1_ack_o    = 1'b0;
      m0_data_o   = s_data_i;
      m1_data_o   = s_data_i;
      cnt_next    = cnt;

      case (state)
         IDLE: begin
            owner_valid = m0_cyc_i | m1_cyc_i;
            owner_idx   = (m0_cyc_i & m1_cyc_i) ? rr_ptr : m1_cyc_i;
            if (owner_valid) begin
               state_next  = owner_idx ? GNT1 : GNT0;
               rr_ptr_next = ~owner_idx;
            end
         end
         GNT0: begin
            in_grant    = 1'b1;
            owner_valid = m0_cyc_i;
            owner_idx   = 1'b0;
            if (!m0_cyc_i) state_next = IDLE;
         end
         GNT1: begin
            in_grant    = 1'b1;
            owner_valid = m1_cyc_i;
            owner_idx   = 1'b1;
            if (!m1_cyc_i) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      // Synthetic ack only in a held grant; a real ack in the same cycle wins
      wd_fire = (TIMEOUT != 16'd0) && in_grant && owner_valid &&
                (cnt == TIMEOUT) && !s_ack_i;

      if (owner_valid) begin
         grant_o = owner_idx ? 2'b10 : 2'b01;
         if (owner_idx) begin
            s_cyc_o  = m1_cyc_i & ~wd_fire;
            s_stb_o  = m1_stb_i & ~wd_fire;
            s_we_o   = m1_we_i;
            s_addr_o = m1_addr_i;
            s_data_o = m1_data_i;
            s_sel_o  = m1_sel_i;
         end else begin
            s_cyc_o  = m0_cyc_i & ~wd_fire;
            s_stb_o  = m0_stb_i & ~wd_fire;
            s_we_o   = m0_we_i;
            s_addr_o = m0_addr_i;
            s_data_o = m0_data_i;
            s_sel_o  = m0_sel_i;
         end
      end

      m0_ack_o = owner_valid & ~owner_idx & (s_ack_i | wd_fire);
      m1_ack_o = owner_valid &  owner_idx & (s_ack_i | wd_fire);
      if (wd_fire && !owner_idx) m0_data_o = TIMEOUT_DATA;
      if (wd_fire &&  owner_idx) m1_data_o = TIMEOUT_DATA;

      if (!s_cyc_o || s_ack_i || wd_fire) begin
         cnt_next = '0;
      end else if (cnt != {CNT_WIDTH{1'b1}}) begin
         cnt_next = cnt + CNT_WIDTH'(1);
      end
   end

   a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
      $onehot0(grant_o));
   a_ack_owner: assert property (@(posedge clk) disable iff (rst)
      !(m0_ack_o && !grant_o[0]) && !(m1_ack_o && !grant_o[1]));
   a_cyc_granted: assert property (@(posedge clk) disable iff (rst)
      !(s_cyc_o && (grant_o == 2'b00)));

endmodule

// File: tb/tb_wb_arbiter_2m1s.sv
// Bench for wb_arbiter_2m1s: vector table, directed corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_wb_arbiter_2m1s;

   localparam logic [15:0] TO    = 16'd4;
   localparam logic [31:0] TDATA = 32'hDEAD_BEEF;
   localparam int          NRND  = 3000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
   logic [31:0] m0_addr, m0_wdat, m1_addr, m1_wdat;
   logic [3:0]  m0_sel, m1_sel;
   logic [31:0] s_rdat;
   logic        s_ack;

   logic [31:0] m0_rdat, m1_rdat, s_addr, s_wdat;
   logic        m0_ack, m1_ack, s_cyc, s_stb, s_we, tmo;
   logic [3:0]  s_sel;
   logic [1:0]  grant;

   logic [31:0] n_m0_rdat, n_m1_rdat, n_s_addr, n_s_wdat;
   logic        n_m0_ack, n_m1_ack, n_s_cyc, n_s_stb, n_s_we, n_tmo;
   logic [3:0]  n_s_sel;
   logic [1:0]  n_grant;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_arbiter_2m1s #(.TIMEOUT(TO), .TIMEOUT_DATA(TDATA)) dut (
      .clk(clk), .rst(rst),
      .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
      .m0_data_i(m0_wdat), .m0_sel_i(m0_sel), .m0_data_o(m0_rdat), .m0_ack_o(m0_ack),
      .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
      .m1_data_i(m1_wdat), .m1_sel_i(m1_sel), .m1_data_o(m1_rdat), .m1_ack_o(m1_ack),
      .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_addr_o(s_addr),
      .s_data_o(s_wdat), .s_sel_o(s_sel), .s_data_i(s_rdat), .s_ack_i(s_ack),
      .grant_o(grant), .timeout_o(tmo));

   wb_arbiter_2m1s #(.TIMEOUT(16'd0), .TIMEOUT_DATA(TDATA)) dut_nowd (
      .clk(clk), .rst(rst),
      .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
      .m0_data_i(m0_wdat), .m0_sel_i(m0_sel), .m0_data_o(n_m0_rdat), .m0_ack_o(n_m0_ack),
      .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
      .m1_data_i(m1_wdat), .m1_sel_i(m1_sel), .m1_data_o(n_m1_rdat), .m1_ack_o(n_m1_ack),
      .s_cyc_o(n_s_cyc), .s_stb_o(n_s_stb), .s_we_o(n_s_we), .s_addr_o(n_s_addr),
      .s_data_o(n_s_wdat), .s_sel_o(n_s_sel), .s_data_i(s_rdat), .s_ack_i(s_ack),
      .grant_o(n_grant), .timeout_o(n_tmo));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdat = '0; m0_sel = '0;
      m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdat = '0; m1_sel = '0;
      s_ack = 1'b0; s_rdat = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   typedef struct {
      logic        rst;
      logic        c0;
      logic        c1;
      logic        ack;
      logic [31:0] rdat;
      logic [1:0]  grant;
      logic        scyc;
      logic        a0;
      logic        a1;
      logic [31:0] addr;
      logic        tmo;
   } vec_t;

   vec_t vecs[13];

   // Reference model state: owner (-1 = none), preferred master on a tie,
   // cycles the slave has been waiting, sticky watchdog flag.
   int owner, pref, elapsed;
   bit sticky;

   initial begin
      int ack_pulses;
      bit fire;
      int cur;
      logic [31:0] e_addr, e_wdat;
      logic [3:0]  e_sel;
      logic        e_cyc, e_stb, e_we, e_a0, e_a1;
      logic [1:0]  e_grant;
      logic [31:0] e_d0, e_d1;

      //            rst c0 c1 ack rdata          grant scyc a0 a1 addr        tmo
      vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,          2'b00,1'b0,1'b0,1'b0,32'h0,   1'b0};
      vecs[1]  = '{1'b0,1'b1,1'b0,1'b1,32'h1234_5678,  2'b01,1'b1,1'b1,1'b0,32'h100, 1'b0};
      vecs[2]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,          2'b00,1'b0,1'b0,1'b0,32'h0,   1'b0};
      vecs[3]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,          2'b00,1'b0,1'b0,1'b0,32'h0,   1'b0};
      vecs[4]  = '{1'b0,1'b1,1'b1,1'b0,32'h0,          2'b01,1'b1,1'b0,1'b0,32'h100, 1'b0};
      vecs[5]  = '{1'b0,1'b1,1'b1,1'b1,32'hCAFE_0001,  2'b01,1'b1,1'b1,1'b0,32'h100, 1'b0};
      vecs[6]  = '{1'b0,1'b0,1'b1,1'b0,32'h0,          2'b00,1'b0,1'b0,1'b0,32'h0,   1'b0};
      vecs[7]  = '{1'b0,1'b1,1'b1,1'b0,32'h0,          2'b10,1'b1,1'b0,1'b0,32'h2000,1'b0};
      vecs[8]  = '{1'b0,1'b1,1'b1,1'b1,32'hCAFE_0002,  2'b10,1'b1,1'b0,1'b1,32'h2000,1'b0};
      vecs[9]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,          2'b00,1'b0,1'b0,1'b0,32'h0,   1'b0};
      vecs[10] = '{1'b0,1'b1,1'b1,1'b1,32'hCAFE_0003,  2'b01,1'b1,1'b1,1'b0,32'h100, 1'b0};
      vecs[11] = '{1'b0,1'b0,1'b0,1'b0,32'h0,          2'b00,1'b0,1'b0,1'b0,32'h0,   1'b0};
      vecs[12] = '{1'b0,1'b0,1'b0,1'b0,32'h0,          2'b00,1'b0,1'b0,1'b0,32'h0,   1'b0};

      clear_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Table: zero-wait read, simultaneous requests, turnaround, round-robin
      for (int i = 0; i < 13; i++) begin
         rst    = vecs[i].rst;
         m0_cyc = vecs[i].c0; m0_stb = vecs[i].c0; m0_we = 1'b0; m0_addr = 32'h100;
         m1_cyc = vecs[i].c1; m1_stb = vecs[i].c1; m1_we = 1'b1; m1_addr = 32'h2000;
         s_ack  = vecs[i].ack; s_rdat = vecs[i].rdat;
         @(negedge clk);
         check($sformatf("vec%0d grant", i), grant, vecs[i].grant);
         check($sformatf("vec%0d s_cyc", i), s_cyc, vecs[i].scyc);
         check($sformatf("vec%0d m0_ack", i), m0_ack, vecs[i].a0);
         check($sformatf("vec%0d m1_ack", i), m1_ack, vecs[i].a1);
         check($sformatf("vec%0d s_addr", i), s_addr, vecs[i].addr);
         check($sformatf("vec%0d m0_data", i), m0_rdat, vecs[i].rdat);
         check($sformatf("vec%0d timeout", i), tmo, vecs[i].tmo);
         tick();
      end
      rst = 1'b0;

      // Wait states: m1 write held four cycles, m0 blocked until after turnaround
      do_reset();
      ack_pulses = 0;
      m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_addr = 32'h2000;
      m1_wdat = 32'hA5A5_0000; m1_sel = 4'b0011;
      for (int c = 0; c < 4; c++) begin
         if (c >= 1) begin m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h100; end
         s_ack = (c == 3);
         @(negedge clk);
         check($sformatf("ws c%0d grant", c), grant, 2'b10);
         check($sformatf("ws c%0d s_cyc", c), s_cyc, 1'b1);
         check($sformatf("ws c%0d s_we", c), s_we, 1'b1);
         check($sformatf("ws c%0d s_addr", c), s_addr, 32'h2000);
         check($sformatf("ws c%0d s_data", c), s_wdat, 32'hA5A5_0000);
         check($sformatf("ws c%0d s_sel", c), s_sel, 4'b0011);
         check($sformatf("ws c%0d m0_ack", c), m0_ack, 1'b0);
         if (m1_ack) ack_pulses++;
         tick();
      end
      m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
      @(negedge clk);
      check("ws turnaround grant", grant, 2'b00);
      check("ws turnaround s_cyc", s_cyc, 1'b0);
      if (m1_ack) ack_pulses++;
      tick();
      s_ack = 1'b1;
      @(negedge clk);
      check("ws m0 grant", grant, 2'b01);
      check("ws m0 s_addr", s_addr, 32'h100);
      check("ws m0 ack", m0_ack, 1'b1);
      if (m1_ack) ack_pulses++;
      check("ws m1 ack pulses", ack_pulses, 1);
      tick();

      // Watchdog: no slave ack, synthetic ack in the 5th granted cycle
      do_reset();
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h300; s_rdat = 32'h77;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         check($sformatf("wd c%0d m0_ack", c), m0_ack, (c == 4));
         check($sformatf("wd c%0d m0_data", c), m0_rdat, (c == 4) ? TDATA : 32'h77);
         check($sformatf("wd c%0d m1_data", c), m1_rdat, 32'h77);
         check($sformatf("wd c%0d s_cyc", c), s_cyc, (c != 4));
         check($sformatf("wd c%0d timeout", c), tmo, (c >= 5));
         check($sformatf("wd c%0d nowd m0_ack", c), n_m0_ack, 1'b0);
         check($sformatf("wd c%0d nowd s_cyc", c), n_s_cyc, 1'b1);
         check($sformatf("wd c%0d nowd timeout", c), n_tmo, 1'b0);
         tick();
      end
      clear_inputs();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("wd idle%0d timeout sticky", c), tmo, 1'b1);
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("wd timeout cleared by reset", tmo, 1'b0);

      // Real ack racing the watchdog wins
      do_reset();
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h400;
      for (int c = 0; c < 5; c++) begin
         s_ack  = (c == 4);
         s_rdat = (c == 4) ? 32'h55 : 32'h0;
         @(negedge clk);
         check($sformatf("race c%0d m0_ack", c), m0_ack, (c == 4));
         check($sformatf("race c%0d s_cyc", c), s_cyc, 1'b1);
         if (c == 4) check("race m0_data", m0_rdat, 32'h55);
         tick();
      end
      clear_inputs();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check($sformatf("race idle%0d timeout", c), tmo, 1'b0);
         tick();
      end

      // Reset in the middle of an m1 wait-state transfer
      do_reset();
      m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_addr = 32'h2000;
      tick();
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h100;
      tick();
      rst = 1'b1;
      @(negedge clk);
      check("mid rst grant during", grant, 2'b10);
      tick();
      rst = 1'b0;
      clear_inputs();
      @(negedge clk);
      check("mid rst grant after", grant, 2'b00);
      check("mid rst s_cyc after", s_cyc, 1'b0);
      check("mid rst timeout after", tmo, 1'b0);
      tick();
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h100;
      m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = 32'h2000;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check($sformatf("mid rst c%0d grant", c), grant, 2'b01);
         check($sformatf("mid rst c%0d m0_ack", c), m0_ack, (c == 4));
         tick();
      end

      // Randomized traffic against the reference model
      do_reset();
      owner = -1; pref = 0; elapsed = 0; sticky = 1'b0;
      for (int n = 0; n < NRND; n++) begin
         rst    = ($urandom_range(999) < 5);
         m0_cyc = m0_cyc ^ ($urandom_range(99) < 15);
         m1_cyc = m1_cyc ^ ($urandom_range(99) < 15);
         m0_stb = m0_cyc ? ($urandom_range(3) != 0) : 1'($urandom_range(1));
         m1_stb = m1_cyc ? ($urandom_range(3) != 0) : 1'($urandom_range(1));
         m0_we  = 1'($urandom_range(1));   m1_we  = 1'($urandom_range(1));
         m0_addr = $urandom;  m1_addr = $urandom;
         m0_wdat = $urandom;  m1_wdat = $urandom;
         m0_sel  = 4'($urandom_range(15)); m1_sel = 4'($urandom_range(15));
         s_ack   = ($urandom_range(99) < 15);
         s_rdat  = $urandom;

         if (owner < 0) begin
            if (m0_cyc && m1_cyc) cur = pref;
            else if (m0_cyc)      cur = 0;
            else if (m1_cyc)      cur = 1;
            else                  cur = -1;
         end else begin
            cur = ((owner == 0) ? m0_cyc : m1_cyc) ? owner : -1;
         end
         fire = (TO != 16'd0) && (owner >= 0) && (cur >= 0) &&
                (elapsed == int'(TO)) && !s_ack;

         e_grant = (cur == 0) ? 2'b01 : (cur == 1) ? 2'b10 : 2'b00;
         e_cyc   = (cur >= 0) && !fire;
         e_stb   = (cur == 0) ? (m0_stb && !fire) : (cur == 1) ? (m1_stb && !fire) : 1'b0;
         e_we    = (cur == 0) ? m0_we   : (cur == 1) ? m1_we   : 1'b0;
         e_addr  = (cur == 0) ? m0_addr : (cur == 1) ? m1_addr : 32'h0;
         e_wdat  = (cur == 0) ? m0_wdat : (cur == 1) ? m1_wdat : 32'h0;
         e_sel   = (cur == 0) ? m0_sel  : (cur == 1) ? m1_sel  : 4'h0;
         e_a0    = (cur == 0) && (s_ack || fire);
         e_a1    = (cur == 1) && (s_ack || fire);
         e_d0    = (fire && cur == 0) ? TDATA : s_rdat;
         e_d1    = (fire && cur == 1) ? TDATA : s_rdat;

         @(negedge clk);
         check("rnd grant", grant, e_grant);
         check("rnd s_cyc", s_cyc, e_cyc);
         check("rnd s_stb", s_stb, e_stb);
         check("rnd s_we", s_we, e_we);
         check("rnd s_addr", s_addr, e_addr);
         check("rnd s_data", s_wdat, e_wdat);
         check("rnd s_sel", s_sel, e_sel);
         check("rnd m0_ack", m0_ack, e_a0);
         check("rnd m1_ack", m1_ack, e_a1);
         check("rnd m0_data", m0_rdat, e_d0);
         check("rnd m1_data", m1_rdat, e_d1);
         check("rnd timeout", tmo, sticky);

         if (rst) begin
            owner = -1; pref = 0; elapsed = 0; sticky = 1'b0;
         end else begin
            sticky = sticky | fire;
            if (!e_cyc || s_ack || fire) elapsed = 0;
            else if (elapsed < 65535)    elapsed++;
            if (owner < 0) begin
               if (cur >= 0) begin owner = cur; pref = 1 - cur; end
            end else if (cur < 0) begin
               owner = -1;
            end
         end
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_arbiter_2m1s.md
Name: wb_arbiter_2m1s

Overview:
- Two-master, one-slave Wishbone arbiter. It sits directly downstream of the two RAM-to-Wishbone sync bridges: m0 is the instruction-side bridge and m1 is the data-side bridge. It drives the single shared SoC Wishbone slave port.
- Arbitration is round-robin with same-cycle grant. Bus ownership is held for the master's whole cycle (cyc high).
- A watchdog returns a synthetic ack when the slave stalls, so the bridges' stall_req can never hang the pipeline.

Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- SEL_WIDTH, 4, byte-select width
- TIMEOUT, 16'd255, cycles without ack before a synthetic ack; 0 disables the watchdog; legal range 0..65535
- TIMEOUT_DATA, 32'hDEAD_BEEF, read data returned with a synthetic ack

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 Wishbone control
- m0_addr_i  in  ADDR_WIDTH  master 0 address
- m0_data_i  in  DATA_WIDTH  master 0 write data
- m0_sel_i  in  SEL_WIDTH  master 0 byte select
- m0_data_o  out  DATA_WIDTH  read data to master 0
- m0_ack_o  out  1  ack to master 0
- m1_*  same set as m0_*, for master 1
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave Wishbone control
- s_addr_o  out  ADDR_WIDTH  slave address
- s_data_o  out  DATA_WIDTH  slave write data
- s_sel_o  out  SEL_WIDTH  slave byte select
- s_data_i  in  DATA_WIDTH  slave read data
- s_ack_i  in  1  slave ack
- grant_o  out  2  one-hot current owner ({m1,m0}); 2'b00 when no owner
- timeout_o  out  1  sticky flag: a watchdog ack has occurred

Behaviour:
- States: IDLE, GNT0, GNT1. Registered state plus registered rr_ptr (0 = m0 preferred on a tie).
- Reset (rst=1 at posedge) sets state=IDLE, rr_ptr=0, cnt=0, timeout_o=0. Reset overrides all other activity, including mid-transfer.
- All outputs except timeout_o are combinational from state and inputs. With no request, every s_* control output is 0, grant_o=0 and m*_ack_o=0.

IDLE:
- Winner selection: if only m0_cyc_i is high, m0 wins. If only m1_cyc_i is high, m1 wins. If both are high, the master indexed by rr_ptr wins.
- The winner is routed to the slave in the same cycle (zero-latency grant). grant_o shows the winner.
- Next state is GNTx for the winner. On that transition rr_ptr <= ~x.
- If no master requests, the state stays IDLE.

GNTx:
- Master x's cyc/stb/we/addr/data/sel are passed to the s_* outputs.
- When mx_cyc_i=0, next state is IDLE. In that cycle s_cyc_o=s_stb_o=0, which gives a one-cycle turnaround before the other master can be granted.
- An ack arriving in the grant cycle with cyc dropping the next cycle is legal: GNTx is entered, then exits to IDLE.

Read data and ack routing:
- m0_data_o and m1_data_o both carry s_data_i.
- The ack goes only to the current owner: mx_ack_o = s_ack_i while x owns the bus, whether granted from IDLE or in GNTx.
- The non-owner's ack is always 0.

Watchdog (TIMEOUT != 0), 16-bit counter cnt:
- cnt <= 0 when s_cyc_o=0, s_ack_i=1, or a synthetic ack fires.
- Otherwise cnt <= cnt+1, saturating at 16'hFFFF.
- A synthetic ack fires when state==GNTx, cnt==TIMEOUT and s_ack_i=0. In that cycle:
  - mx_ack_o=1
  - mx_data_o=TIMEOUT_DATA
  - s_cyc_o=s_stb_o=0 (the slave transfer is aborted)
  - timeout_o <= 1, which holds until reset
- A real s_ack_i in the same cycle as cnt==TIMEOUT takes priority: it is a normal ack and timeout_o is unchanged.
- With TIMEOUT=0 the watchdog never fires.

Assertions:
- grant_o has at most one bit set.
- The non-owner never sees an ack.
- s_cyc_o is never 1 with grant_o=0.

Test Plan:
- Single master, zero-wait: m0 reads addr 0x100, slave acks in the grant cycle with 0x1234_5678 -> m0_ack_o=1 and m0_data_o=0x1234_5678 in cycle 0; state goes GNT0 then IDLE; m1_ack_o stays 0.
- Simultaneous requests after reset: m0 and m1 both raise cyc -> m0 is granted first (grant_o=01); after m0 drops cyc there is one idle cycle, then m1 is granted (grant_o=10); on the next simultaneous request, m0 wins again (rr_ptr alternates).
- Wait states: m1 writes 0xA5A5_0000 to 0x2000 with sel=4'b0011; slave acks after 3 cycles -> s_* outputs hold m1's values for all 4 cycles; m1_ack_o pulses exactly once; m0's request is blocked until the turnaround cycle.
- Watchdog: TIMEOUT=4, slave never acks, m0 reads -> in the 5th cycle from grant, m0_ack_o=1, m0_data_o=0xDEAD_BEEF and s_cyc_o=0; timeout_o=1 from the next cycle and stays high until rst.
- Ack racing the timeout: TIMEOUT=4, slave acks exactly in the cnt==4 cycle with 0x55 -> m0_data_o=0x55 and timeout_o stays 0.
- Reset mid-transfer: assert rst during GNT1 wait states -> next cycle state=IDLE, grant_o=0, s_cyc_o=0, cnt=0, rr_ptr=0.
